// File: rtl/sha_block_padder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sha_block_padder
// Description : Packs a byte stream into SHA message blocks with standard
//               padding (0x80, zero fill, big-endian bit length) and hands
//               each block to the hash core under a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_block_padder #(
    parameter int IN_BYTES   = 1,
    parameter int BLOCK_BITS = 1024,
    parameter int LEN_BITS   = 128,
    parameter int CNT_W      = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [8*IN_BYTES-1:0]            s_data,
    input  logic [$clog2(IN_BYTES+1)-1:0]    s_cnt,
    input  logic                             s_last,
    output logic [BLOCK_BITS-1:0]            blk_data,
    output logic                             blk_start,
    output logic                             blk_first,
    output logic                             blk_last,
    input  logic                             core_done,
    output logic                             msg_done,
    output logic                             busy
);

    localparam int c_blk_bytes = BLOCK_BITS / 8;
    localparam int c_len_bytes = LEN_BITS / 8;
    localparam int c_ptr_w     = $clog2(c_blk_bytes + 1);
    localparam logic [c_ptr_w-1:0] c_blk_ptr = c_ptr_w'(c_blk_bytes);

    typedef enum logic [2:0] {
        ST_FILL  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PAD   = 3'd3,
        ST_LENB  = 3'd4
    } state_t;

    state_t                 r_state, w_state_next;
    logic [c_ptr_w-1:0]     r_ptr, w_ptr_next, w_ptr_sum;
    logic [CNT_W-1:0]       r_count, w_count_next;
    logic                   r_first_flag, w_first_next;
    logic [BLOCK_BITS-1:0]  r_buf, w_buf_next;
    logic                   r_pend_len, w_pend_len_next;
    logic                   r_pend_80, w_pend_80_next;
    logic [BLOCK_BITS-1:0]  r_blk_data;
    logic                   r_blk_first;
    logic                   r_blk_last, w_last_next;
    logic [LEN_BITS-1:0]    w_len;

    assign w_ptr_sum = r_ptr + c_ptr_w'(s_cnt);
    assign w_len     = LEN_BITS'({r_count, 3'b000});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FILL;
            r_ptr        <= '0;
            r_count      <= '0;
            r_first_flag <= 1'b1;
            r_buf        <= '0;
            r_pend_len   <= 1'b0;
            r_pend_80    <= 1'b0;
            r_blk_data   <= '0;
            r_blk_first  <= 1'b0;
            r_blk_last   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ptr        <= w_ptr_next;
            r_count      <= w_count_next;
            r_first_flag <= w_first_next;
            r_buf        <= w_buf_next;
            r_pend_len   <= w_pend_len_next;
            r_pend_80    <= w_pend_80_next;
            r_blk_last   <= w_last_next;
            // The core-facing copy only moves when a block is launched.
            if (w_state_next == ST_ISSUE) begin
                r_blk_data  <= w_buf_next;
                r_blk_first <= r_first_flag;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_count_next    = r_count;
        w_first_next    = r_first_flag;
        w_buf_next      = r_buf;
        w_pend_len_next = r_pend_len;
        w_pend_80_next  = r_pend_80;
        w_last_next     = r_blk_last;

        case (r_state)
            ST_FILL: begin
                if (s_valid) begin
                    for (int j = 0; j < IN_BYTES; j++) begin
                        if ((j < int'(s_cnt)) && ((int'(r_ptr) + j) < c_blk_bytes)) begin
                            w_buf_next[BLOCK_BITS-1-8*(int'(r_ptr)+j) -: 8] =
                                s_data[8*IN_BYTES-1-8*j -: 8];
                        end
                    end
                    w_ptr_next   = w_ptr_sum;
                    w_count_next = r_count + CNT_W'(s_cnt);
                    if (s_last) begin
                        w_state_next = ST_PAD;
                    end else if (w_ptr_sum == c_blk_ptr) begin
                        w_state_next = ST_ISSUE;
                        w_last_next  = 1'b0;
                    end
                end
            end

            ST_PAD: begin
                if (r_ptr < c_blk_ptr) begin
                    w_buf_next[BLOCK_BITS-1-8*int'(r_ptr) -: 8] = 8'h80;
                end
                if ((int'(r_ptr) + 1) <= (c_blk_bytes - c_len_bytes)) begin
                    w_buf_next[LEN_BITS-1:0] = w_len;
                    w_last_next              = 1'b1;
                end else begin
                    // Length does not fit: it goes in an extra block, and a
                    // completely full data block also defers the 0x80 marker.
                    w_last_next     = 1'b0;
                    w_pend_len_next = 1'b1;
                    w_pend_80_next  = (r_ptr == c_blk_ptr);
                end
                w_state_next = ST_ISSUE;
            end

            ST_ISSUE: begin
                w_first_next = 1'b0;
                w_state_next = ST_WAIT;
            end

            ST_WAIT: begin
                if (core_done) begin
                    w_buf_next = '0;
                    w_ptr_next = '0;
                    if (r_blk_last) begin
                        w_first_next = 1'b1;
                        w_count_next = '0;
                        w_state_next = ST_FILL;
                    end else if (r_pend_len) begin
                        w_state_next = ST_LENB;
                    end else begin
                        w_state_next = ST_FILL;
                    end
                end
            end

            ST_LENB: begin
                if (r_pend_80) begin
                    w_buf_next[BLOCK_BITS-1 -: 8] = 8'h80;
                end
                w_buf_next[LEN_BITS-1:0] = w_len;
                w_pend_len_next          = 1'b0;
                w_pend_80_next           = 1'b0;
                w_last_next              = 1'b1;
                w_state_next             = ST_ISSUE;
            end

            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    assign s_ready   = !reset && (r_state == ST_FILL);
    assign blk_start = !reset && (r_state == ST_ISSUE);
    assign msg_done  = !reset && (r_state == ST_WAIT) && core_done && r_blk_last;
    assign busy      = !reset && !((r_state == ST_FILL) && (r_ptr == '0) && r_first_flag);
    assign blk_data  = r_blk_data;
    assign blk_first = r_blk_first;
    assign blk_last  = r_blk_last;

endmodule
`default_nettype wire

// File: tb/tb_sha_block_padder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sha_block_padder
// Description : Bench for sha_block_padder in SHA-512/byte-wide and
//               SHA-256/word-wide configurations against a padding model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha_block_padder;

    typedef struct {
        logic [1023:0] data;
        bit            first;
        bit            last;
    } blk_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: SHA-512, one byte per beat
    logic          s_valid_a = 1'b0, s_ready_a, s_last_a = 1'b0;
    logic [7:0]    s_data_a = '0;
    logic [0:0]    s_cnt_a = '0;
    logic [1023:0] blk_data_a;
    logic          blk_start_a, blk_first_a, blk_last_a, msg_done_a, busy_a;
    logic          core_done_a = 1'b0;

    // Instance B: SHA-256, four bytes per beat
    logic          s_valid_b = 1'b0, s_ready_b, s_last_b = 1'b0;
    logic [31:0]   s_data_b = '0;
    logic [2:0]    s_cnt_b = '0;
    logic [511:0]  blk_data_b;
    logic          blk_start_b, blk_first_b, blk_last_b, msg_done_b, busy_b;
    logic          core_done_b = 1'b0;

    sha_block_padder dut_a (
        .clk(clk), .reset(reset),
        .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
        .s_cnt(s_cnt_a), .s_last(s_last_a),
        .blk_data(blk_data_a), .blk_start(blk_start_a), .blk_first(blk_first_a),
        .blk_last(blk_last_a), .core_done(core_done_a), .msg_done(msg_done_a),
        .busy(busy_a)
    );

    sha_block_padder #(.IN_BYTES(4), .BLOCK_BITS(512), .LEN_BITS(64), .CNT_W(64)) dut_b (
        .clk(clk), .reset(reset),
        .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
        .s_cnt(s_cnt_b), .s_last(s_last_b),
        .blk_data(blk_data_b), .blk_start(blk_start_b), .blk_first(blk_first_b),
        .blk_last(blk_last_b), .core_done(core_done_b), .msg_done(msg_done_b),
        .busy(busy_b)
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    blk_t model_q[$];
    blk_t exp_a[$];
    blk_t exp_b[$];
    int   delay_a = 1;
    int   delay_b = 3;
    bit   abort_a = 1'b0;
    bit   cur_last_a = 1'b0;
    bit   cur_last_b = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [1023:0] act, input logic [1023:0] want);
        int idx;
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            idx = 0;
            for (int i = 127; i >= 0; i--)
                if (act[1023-8*i -: 8] !== want[1023-8*i -: 8]) idx = i;
            $display("FAIL %s: byte %0d got %h expected %h", nm, idx,
                     act[1023-8*idx -: 8], want[1023-8*idx -: 8]);
        end
    endtask

    // Padded message = msg ++ 0x80 ++ zeros ++ big-endian bit length, cut
    // into bb-byte blocks; data is right-aligned in the 1024-bit field.
    function automatic void model_build(input byte unsigned msg[$], input int bb, input int lb);
        byte unsigned    s[$];
        longint unsigned bits;
        blk_t            b;
        int              nblk;
        model_q.delete();
        s = msg;
        s.push_back(8'h80);
        while ((s.size() % bb) != (bb - lb)) s.push_back(8'h00);
        bits = longint'(msg.size()) * 8;
        for (int i = lb - 1; i >= 0; i--) s.push_back((i < 8) ? 8'(bits >> (8*i)) : 8'h00);
        nblk = s.size() / bb;
        for (int k = 0; k < nblk; k++) begin
            b.data = '0;
            for (int i = 0; i < bb; i++) b.data[8*(bb-1-i) +: 8] = s[k*bb+i];
            b.first = (k == 0);
            b.last  = (k == nblk - 1);
            model_q.push_back(b);
        end
    endfunction

    task automatic beat_a(input logic [7:0] d, input logic c, input logic last);
        int g = 0;
        s_valid_a = 1'b1; s_data_a = d; s_cnt_a = c; s_last_a = last;
        while (!s_ready_a && g < 500) begin @(negedge clk); g++; end
        if (g >= 500) chk("beat_a_timeout", 64'(g), 64'd0);
        @(negedge clk);
        s_valid_a = 1'b0;
    endtask

    task automatic beat_b(input logic [31:0] d, input logic [2:0] c, input logic last);
        int g = 0;
        s_valid_b = 1'b1; s_data_b = d; s_cnt_b = c; s_last_b = last;
        while (!s_ready_b && g < 500) begin @(negedge clk); g++; end
        if (g >= 500) chk("beat_b_timeout", 64'(g), 64'd0);
        @(negedge clk);
        s_valid_b = 1'b0;
    endtask

    task automatic send_a(input byte unsigned msg[$]);
        model_build(msg, 128, 16);
        foreach (model_q[k]) exp_a.push_back(model_q[k]);
        if (msg.size() == 0) beat_a(8'h00, 1'b0, 1'b1);
        else for (int i = 0; i < msg.size(); i++) beat_a(msg[i], 1'b1, (i == msg.size() - 1));
    endtask

    task automatic send_b(input byte unsigned msg[$]);
        logic [31:0] d;
        int          c;
        model_build(msg, 64, 8);
        foreach (model_q[k]) exp_b.push_back(model_q[k]);
        if (msg.size() == 0) beat_b(32'h0, 3'd0, 1'b1);
        for (int i = 0; i < msg.size(); i += 4) begin
            d = '0;
            c = (msg.size() - i < 4) ? (msg.size() - i) : 4;
            for (int j = 0; j < c; j++) d[31-8*j -: 8] = msg[i+j];
            beat_b(d, 3'(c), (i + 4 >= msg.size()));
        end
    endtask

    task automatic wait_idle(input bit which_b);
        int g = 0;
        while (((which_b ? exp_b.size() : exp_a.size()) != 0 || (which_b ? busy_b : busy_a))
               && g < 5000) begin
            @(negedge clk); g++;
        end
        chk(which_b ? "idle_b_timeout" : "idle_a_timeout", 64'(g >= 5000), 64'd0);
    endtask

    // Compare process: every cycle, blocks issued and held outputs vs model.
    logic [1023:0] hold_a_data = '0, hold_b_data = '0;
    bit hold_a_first = 0, hold_a_last = 0, hold_b_first = 0, hold_b_last = 0;
    initial begin
        blk_t e;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                hold_a_data = '0; hold_a_first = 0; hold_a_last = 0;
                hold_b_data = '0; hold_b_first = 0; hold_b_last = 0;
                chk("rst_s_ready_a", s_ready_a, 0);
                chk("rst_blk_start_a", blk_start_a, 0);
                chk("rst_busy_a", busy_a, 0);
                chk("rst_s_ready_b", s_ready_b, 0);
                chk("rst_busy_b", busy_b, 0);
            end else begin
                if (blk_start_a) begin
                    if (exp_a.size() == 0) chk("unexpected_blk_start_a", 1, 0);
                    else begin
                        e = exp_a.pop_front();
                        hold_a_data = e.data; hold_a_first = e.first; hold_a_last = e.last;
                        cur_last_a = e.last;
                    end
                end
                if (blk_start_b) begin
                    if (exp_b.size() == 0) chk("unexpected_blk_start_b", 1, 0);
                    else begin
                        e = exp_b.pop_front();
                        hold_b_data = e.data; hold_b_first = e.first; hold_b_last = e.last;
                        cur_last_b = e.last;
                    end
                end
            end
            chk_blk("blk_data_a", blk_data_a, hold_a_data);
            chk("blk_first_a", blk_first_a, hold_a_first);
            chk("blk_last_a", blk_last_a, hold_a_last);
            chk_blk("blk_data_b", {512'b0, blk_data_b}, hold_b_data);
            chk("blk_first_b", blk_first_b, hold_b_first);
            chk("blk_last_b", blk_last_b, hold_b_last);
        end
    end

    // Hash-core stand-ins: answer each block after a programmable delay.
    initial begin
        forever begin
            @(negedge clk);
            if (blk_start_a) begin
                for (int k = 0; k < delay_a; k++) begin
                    @(negedge clk);
                    if (k == 1) chk("s_ready_a_in_wait", s_ready_a, 0);
                end
                if (!abort_a && !reset) begin
                    core_done_a = 1'b1;
                    #1 chk("msg_done_a", msg_done_a, cur_last_a);
                    @(negedge clk);
                    core_done_a = 1'b0;
                    #1 chk("msg_done_a_low", msg_done_a, 0);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (blk_start_b) begin
                for (int k = 0; k < delay_b; k++) @(negedge clk);
                if (!reset) begin
                    core_done_b = 1'b1;
                    #1 chk("msg_done_b", msg_done_b, cur_last_b);
                    @(negedge clk);
                    core_done_b = 1'b0;
                end
            end
        end
    end

    initial begin
        byte unsigned m[$];

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready_a", s_ready_a, 1);
        chk("post_rst_busy_a", busy_a, 0);
        chk("post_rst_s_ready_b", s_ready_b, 1);

        // "abc"
        m = '{8'h61, 8'h62, 8'h63};
        model_build(m, 128, 16);
        chk("model_abc_nblk", 64'(model_q.size()), 64'd1);
        chk("model_abc_head", model_q[0].data[1023:992], 64'h61626380);
        chk("model_abc_len", model_q[0].data[63:0], 64'h18);
        send_a(m);
        wait_idle(0);

        // 111 bytes: marker and length share one block
        m.delete();
        for (int i = 0; i < 111; i++) m.push_back(8'(i * 7 + 1));
        model_build(m, 128, 16);
        chk("model_111_nblk", 64'(model_q.size()), 64'd1);
        chk("model_111_80", model_q[0].data[1023-8*111 -: 8], 64'h80);
        chk("model_111_len", model_q[0].data[63:0], 64'h378);
        send_a(m);
        wait_idle(0);

        // 112 bytes: length spills into a second block
        m.push_back(8'hA5);
        model_build(m, 128, 16);
        chk("model_112_nblk", 64'(model_q.size()), 64'd2);
        chk("model_112_80", model_q[0].data[1023-8*112 -: 8], 64'h80);
        chk("model_112_len", model_q[1].data[63:0], 64'h380);
        send_a(m);
        wait_idle(0);

        // 128 bytes: full data block, marker deferred to byte 0 of the next
        m.delete();
        for (int i = 0; i < 128; i++) m.push_back(8'(255 - i));
        model_build(m, 128, 16);
        chk("model_128_80", model_q[1].data[1023:1016], 64'h80);
        chk("model_128_len", model_q[1].data[63:0], 64'h400);
        send_a(m);
        wait_idle(0);

        // empty message
        m.delete();
        model_build(m, 128, 16);
        chk("model_empty_80", model_q[0].data[1023:1016], 64'h80);
        chk("model_empty_rest", 64'(model_q[0].data[1015:0] == '0), 64'd1);
        send_a(m);
        wait_idle(0);

        // word-wide SHA-256: 7 bytes, final beat carries 3
        m = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        model_build(m, 64, 8);
        chk("model_b7_80", model_q[0].data[511-56 -: 8], 64'h80);
        chk("model_b7_len", model_q[0].data[63:0], 64'h38);
        send_b(m);
        wait_idle(1);

        m.delete();
        for (int i = 0; i < 60; i++) m.push_back(8'(i + 3));
        send_b(m);
        wait_idle(1);

        // slow core: beats stall through WAIT
        delay_a = 20;
        m.delete();
        for (int i = 0; i < 200; i++) m.push_back(8'(i * 13 + 5));
        send_a(m);
        wait_idle(0);
        delay_a = 1;

        // reset while the first block of a message waits on the core
        abort_a = 1'b1;
        m.delete();
        for (int i = 0; i < 130; i++) m.push_back(8'(i ^ 8'h5A));
        model_build(m, 128, 16);
        exp_a.push_back(model_q[0]);
        for (int i = 0; i < 128; i++) beat_a(m[i], 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_wait_ready", s_ready_a, 0);
        chk("abort_wait_busy", busy_a, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_busy", busy_a, 0);
        chk("abort_ready", s_ready_a, 1);
        abort_a = 1'b0;

        m = '{8'h61, 8'h62, 8'h63};
        send_a(m);
        wait_idle(0);

        chk("exp_a_drained", 64'(exp_a.size()), 64'd0);
        chk("exp_b_drained", 64'(exp_b.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
